// File: rtl/seg7_scan_display.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
// Per-digit DP and blanking, PWM brightness, leading-zero suppression, and a
// once-per-frame snapshot of the inputs so a digit never shows a half-updated value.
module seg7_scan_display #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int PWM_BITS   = 4
) (
  input  logic                      CLK100MHZ,
  input  logic                      CPU_RESETN,
  input  logic [4*NUM_DIGITS-1:0]   DATA,
  input  logic [NUM_DIGITS-1:0]     DP_IN,
  input  logic [NUM_DIGITS-1:0]     BLANK,
  input  logic                      LZ_EN,
  input  logic [PWM_BITS-1:0]       BRIGHT,
  output logic [NUM_DIGITS-1:0]     AN,
  output logic [6:0]                SEG,
  output logic                      DP,
  output logic                      FRAME_STB
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]          presc;
  logic [IDX_W-1:0]          idx;
  logic [PWM_BITS-1:0]       pwm_cnt;
  logic [4*NUM_DIGITS-1:0]   shadow_data;
  logic [NUM_DIGITS-1:0]     shadow_dp;
  logic [NUM_DIGITS-1:0]     shadow_blank;
  logic [NUM_DIGITS-1:0]     lz_mask;
  logic                      tick;
  logic                      wrap;
  logic                      pwm_on;
  logic [3:0]                cur_nib;
  logic                      cur_dp;
  logic                      cur_blank;
  logic [NUM_DIGITS-1:0]     an_next;

  // Active-low glyph for one hex nibble, bit order {CG..CA}.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h18;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h27;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  assign tick   = (presc == PRE_LAST);
  assign wrap   = tick && (idx == IDX_LAST);
  assign pwm_on = (&BRIGHT) | (pwm_cnt < BRIGHT);

  // Prescaler: DIV clocks per digit slot.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!CPU_RESETN)      presc <= '0;
    else if (tick)        presc <= '0;
    else                  presc <= presc + 1'b1;
  end

  // Digit index advances once per slot and wraps after the last digit.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)      idx <= '0;
    else if (tick)        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
  end

  // Free-running PWM counter.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) pwm_cnt <= '0;
    else             pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Leading-zero mask from the live inputs; only used at capture time.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    logic all_zero;
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero & (DATA[4*k +: 4] == 4'h0);
      lz_mask[k] = LZ_EN & all_zero;
    end
  end

  // Frame snapshot on the wrap tick, plus the one-cycle strobe announcing it.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    // NOTE: the shadow registers are reset (blank mask all ones) so the display stays dark until the first capture.
    if (!CPU_RESETN) begin
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '1;
      FRAME_STB    <= 1'b0;
    end else begin
      FRAME_STB <= wrap;
      if (wrap) begin
        shadow_data  <= DATA;
        shadow_dp    <= DP_IN;
        shadow_blank <= BLANK | lz_mask;
      end
    end
  end

  // Select the shadow nibble, DP and blank bit of the current digit, and build the anode pattern.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    an_next   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = shadow_data[4*i +: 4];
        cur_dp    = shadow_dp[i];
        cur_blank = shadow_blank[i];
        an_next[i] = ~(pwm_on & ~shadow_blank[i]);
      end
    end
  end

  // Registered pin drivers; AN and SEG change on the same edge.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      AN  <= '1;
      SEG <= 7'h7F;
      DP  <= 1'b1;
    end else begin
      AN  <= an_next;
      SEG <= glyph(cur_nib);
      DP  <= ~cur_dp;
    end
  end

  // The blank bit of the selected digit is already folded into an_next.
  logic unused_cur_blank;
  assign unused_cur_blank = cur_blank;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display with 4 digits, 4 clocks per digit, 2-bit PWM.
// A time-based model (edge count since reset release) predicts every output each cycle;
// directed literal checks pin the model to hand-computed values.
module tb_seg7_scan_display;

  localparam int ND    = 4;
  localparam int DIVT  = 4;
  localparam int FRAME = ND * DIVT;

  logic          clk;
  logic          rst_n;
  logic [15:0]   data;
  logic [3:0]    dp_in;
  logic [3:0]    blank;
  logic          lz_en;
  logic [1:0]    bright;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_stb;

  int total = 0;
  int bad   = 0;
  int cur   = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  seg7_scan_display #(
    .NUM_DIGITS(ND), .CLK_HZ(16), .SCAN_HZ(4), .PWM_BITS(2)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .DATA      (data),
    .DP_IN     (dp_in),
    .BLANK     (blank),
    .LZ_EN     (lz_en),
    .BRIGHT    (bright),
    .AN        (an),
    .SEG       (seg),
    .DP        (dp),
    .FRAME_STB (frame_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Digits above the highest non-zero nibble are dark when suppression is on.
  function automatic logic [3:0] lz_blank(input logic [15:0] d, input logic lz);
    int hi = 0;
    logic [3:0] m = 4'h0;
    for (int k = 0; k < ND; k++) if (((d >> (4*k)) & 16'hF) != 0) hi = k;
    for (int k = 0; k < ND; k++) if (lz && k > hi) m[k] = 1'b1;
    return m;
  endfunction

  // Model: outputs after edge n reflect scan position n-1; snapshots land on multiples of FRAME.
  int          n = 0;
  int          m_pos, m_idx, m_pwm;
  logic [15:0] s_data  = '0;
  logic [3:0]  s_dp    = '0;
  logic [3:0]  s_blank = 4'hF;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_stb;

  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0; s_data = '0; s_dp = '0; s_blank = 4'hF;
      #1;
      check("rst_an", an, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_dp", dp, 1'b1);
      check("rst_stb", frame_stb, 1'b0);
    end else begin
      n++;
      m_pos = n - 1;
      m_idx = (m_pos / DIVT) % ND;
      m_pwm = m_pos % 4;
      e_an  = 4'hF;
      if (((bright == 2'd3) || (m_pwm < int'(bright))) && !s_blank[m_idx]) e_an[m_idx] = 1'b0;
      e_seg = glyph_tab[(s_data >> (4*m_idx)) & 16'hF];
      e_dp  = ~s_dp[m_idx];
      e_stb = (n % FRAME == 0);
      if (n % FRAME == 0) begin
        s_data = data; s_dp = dp_in; s_blank = blank | lz_blank(data, lz_en);
      end
      #1;
      check("an", an, e_an);
      check("seg", seg, e_seg);
      check("dp", dp, e_dp);
      check("stb", frame_stb, e_stb);
    end
  end

  // Advance to 2 time units after edge number target (counted since reset release).
  task automatic go(input int target);
    while (cur < target) begin
      @(posedge clk);
      cur++;
    end
    #2;
  endtask

  int lows;

  initial begin
    rst_n = 1'b1; data = 16'h12AF; dp_in = 4'b0100; blank = 4'h0; lz_en = 1'b0; bright = 2'd3;
    #2 rst_n = 1'b0;
    #1;
    check("t0_an", an, 4'hF);
    check("t0_seg", seg, 7'h7F);
    check("t0_dp", dp, 1'b1);
    check("t0_stb", frame_stb, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cur = 0;

    // Startup: dark for 16 cycles, then 12AF scanned right to left.
    go(16); check("start_dark", an, 4'hF); check("first_stb", frame_stb, 1'b1);
    go(17); check("d0_an", an, 4'b1110); check("d0_seg", seg, 7'h0E); check("d0_dp", dp, 1'b1);
    go(21); check("d1_an", an, 4'b1101); check("d1_seg", seg, 7'h08);
    go(25); check("d2_an", an, 4'b1011); check("d2_seg", seg, 7'h24); check("d2_dp", dp, 1'b0);
    go(29); check("d3_an", an, 4'b0111); check("d3_seg", seg, 7'h79); check("d3_dp", dp, 1'b1);

    // Leading-zero suppression.
    data = 16'h0070; lz_en = 1'b1; dp_in = 4'h0;
    go(33); check("lz_d0_an", an, 4'b1110); check("lz_d0_seg", seg, 7'h40);
    go(37); check("lz_d1_an", an, 4'b1101); check("lz_d1_seg", seg, 7'h78);
    go(41); check("lz_d2_dark", an, 4'hF);
    go(45); check("lz_d3_dark", an, 4'hF);
    data = 16'h0000;
    go(49); check("zero_d0_an", an, 4'b1110); check("zero_d0_seg", seg, 7'h40);
    go(53); check("zero_d1_dark", an, 4'hF);

    // Mid-frame data change stays invisible until the wrap.
    data = 16'h1234; lz_en = 1'b0;
    go(65); check("f_d0_seg", seg, 7'h19);
    go(69); check("f_d1_an", an, 4'b1101); check("f_d1_seg", seg, 7'h30);
    data = 16'hABCD;
    go(73); check("hold_d2_seg", seg, 7'h24);
    go(77); check("hold_d3_seg", seg, 7'h79);
    go(80); check("wrap_stb", frame_stb, 1'b1);
    go(81); check("wrap_stb_end", frame_stb, 1'b0); check("new_d0_seg", seg, 7'h21);
    go(85); check("new_d1_seg", seg, 7'h27);

    // Brightness: 1 of 4, none, all.
    bright = 2'd1;
    lows = 0;
    for (int e = 89; e <= 92; e++) begin go(e); if (an != 4'hF) lows++; end
    check("bright1_lows", lows, 1);
    go(89 - 89 + 92); // already there; keeps position explicit
    bright = 2'd0;
    lows = 0;
    for (int e = 93; e <= 96; e++) begin go(e); if (an != 4'hF) lows++; end
    check("bright0_lows", lows, 0);
    bright = 2'd3;
    lows = 0;
    for (int e = 97; e <= 100; e++) begin go(e); if (an == 4'b1110) lows++; end
    check("bright3_lows", lows, 4);

    // Asynchronous reset mid-digit, then the same startup again.
    data = 16'h12AF; dp_in = 4'b0100; lz_en = 1'b0;
    go(102);
    #1 rst_n = 1'b0;
    #1;
    check("ar_an", an, 4'hF);
    check("ar_seg", seg, 7'h7F);
    check("ar_dp", dp, 1'b1);
    check("ar_stb", frame_stb, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cur = 0;
    go(16); check("re_dark", an, 4'hF);
    go(17); check("re_d0_an", an, 4'b1110); check("re_d0_seg", seg, 7'h0E);
    go(25); check("re_d2_an", an, 4'b1011); check("re_d2_dp", dp, 1'b0);

    // Glyph sweep on digit 0 with the other digits blanked.
    blank = 4'b1110;
    for (int v = 0; v < 16; v++) begin
      data = 16'(v);
      go(32 + FRAME*v + 1);
      check($sformatf("glyph_%0h", v), seg, glyph_tab[v]);
      check($sformatf("glyph_an_%0h", v), an, 4'b1110);
      go(32 + FRAME*v + 5);
      check($sformatf("blank_an_%0h", v), an, 4'hF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
